// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the two-master data-memory arbiter: access widths,
// FSM states and master ids.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        W_WORD    = 2'b00,
        W_HALF    = 2'b01,
        W_BYTE    = 2'b10,
        W_ILLEGAL = 2'b11
    } width_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WRITE   = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dm_lane.sv
// Sub-word lane handling: extract and extend a half/byte for loads, and merge
// store data into the matching lane of the word read back from memory.
module dm_lane
    import dm_arbiter_pkg::*;
(
    input  width_e      width,
    input  logic [1:0]  off,
    input  logic        sign,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [15:0] hw;
    logic [7:0]  bt;

    always_comb begin
        hw    = off[1] ? rword[31:16] : rword[15:0];
        bt    = rword[{off, 3'b000} +: 8];
        ldata = rword;
        mword = wdata;
        case (width)
            W_HALF: begin
                ldata = {{16{sign & hw[15]}}, hw};
                mword = off[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]};
            end
            W_BYTE: begin
                ldata = {{24{sign & bt[7]}}, bt};
                mword = rword;
                mword[{off, 3'b000} +: 8] = wdata[7:0];
            end
            default: begin
                ldata = rword;
                mword = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one word-wide SRAM between the CPU and a DMA port,
// turning half/byte accesses into whole-word reads, merges and writes.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_width,
    input  logic              m0_sign,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_width,
    input  logic              m1_sign,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    state_e state, state_nx;

    logic        any_req, sel;
    logic        s_we, s_sign, s_err;
    logic [1:0]  s_width;
    logic [31:0] s_addr, s_wdata;

    logic              gid, last_grant, r_we, r_sign, r_err;
    width_e            r_width;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata, r_data;
    logic [31:0]       ld_word, mg_word;

    // On contention the master that did not win last time goes first.
    assign any_req = m0_req | m1_req;
    assign sel     = (m0_req & m1_req) ? ~last_grant : m1_req;

    assign s_we    = sel ? m1_we    : m0_we;
    assign s_width = sel ? m1_width : m0_width;
    assign s_sign  = sel ? m1_sign  : m0_sign;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign s_err = (s_width == W_ILLEGAL)
                 | ((s_width == W_WORD) & (s_addr[1:0] != 2'b00))
                 | ((s_width == W_HALF) & s_addr[0])
                 | ((s_addr >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (s_err)                          state_nx = S_RESP;
                    else if (s_we && s_width == W_WORD) state_nx = S_WRITE;
                    else                                state_nx = S_READ;
                end
            end
            S_READ: begin
                mem_en   = 1'b1;
                mem_addr = r_addr[ADDR_W+1:2];
                state_nx = S_WAIT_RD;
            end
            S_WAIT_RD: state_nx = r_we ? S_WRITE : S_RESP;
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr[ADDR_W+1:2];
                mem_wdata = (r_width == W_WORD) ? r_wdata : r_data;
                state_nx  = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gid        <= M0;
            last_grant <= M1;
            r_we       <= 1'b0;
            r_sign     <= 1'b0;
            r_err      <= 1'b0;
            r_width    <= W_WORD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                gid        <= sel;
                last_grant <= sel;
                r_we       <= s_we;
                r_sign     <= s_sign;
                r_err      <= s_err;
                r_width    <= width_e'(s_width);
                r_addr     <= s_addr[ADDR_W+1:0];
                r_wdata    <= s_wdata;
                r_data     <= '0;
            end
            // Holds the load result, or the merged word for a sub-word store.
            if (state == S_WAIT_RD) r_data <= r_we ? mg_word : ld_word;
        end
    end

    dm_lane u_lane (
        .width (r_width),
        .off   (r_addr[1:0]),
        .sign  (r_sign),
        .rword (mem_rdata),
        .wdata (r_wdata),
        .ldata (ld_word),
        .mword (mg_word)
    );

    assign busy     = (state != S_IDLE);
    assign m0_ack   = (state == S_RESP) & (gid == M0);
    assign m1_ack   = (state == S_RESP) & (gid == M1);
    assign m0_err   = m0_ack & r_err;
    assign m1_err   = m1_ack & r_err;
    assign m0_rdata = (m0_ack & ~r_we) ? r_data : 32'd0;
    assign m1_rdata = (m1_ack & ~r_we) ? r_data : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural SRAM model; latencies,
// lane handling, errors, arbitration order and mid-operation reset.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_sign, m1_req, m1_we, m1_sign;
    logic [1:0]  m0_width, m1_width;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];
    int          wr_cnt = 0, rd_cnt = 0;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    dm_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_width(m0_width), .m0_sign(m0_sign),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_width(m1_width), .m1_sign(m1_sign),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_cnt    <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    // One transaction on master m; lat=0 means no ack within the bound.
    task automatic do_req(input int m, input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        logic quiet;
        wait_idle();
        if (m == 0) begin
            m0_we = we; m0_width = w; m0_sign = s; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_width = w; m1_sign = s; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
        end
        lat = 0; rd = 32'd0; er = 1'b0; quiet = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (m == 0 && (m1_ack || m1_err || m1_rdata != 0)) quiet = 1'b0;
            if (m == 1 && (m0_ack || m0_err || m0_rdata != 0)) quiet = 1'b0;
            if ((m == 0) ? m0_ack : m1_ack) begin
                lat = i;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                er  = (m == 0) ? m0_err : m1_err;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("other_master_quiet", {31'd0, quiet}, 32'd1);
    endtask

    int          lat, wc, rc, n, dual;
    logic [31:0] rd;
    logic        er;
    int          order [4];
    logic [31:0] got [4];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
        m0_req = 0; m0_we = 0; m0_width = 0; m0_sign = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_width = 0; m1_sign = 0; m1_addr = 0; m1_wdata = 0;
        reset = 1'b1;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk); reset = 1'b0;

        // word store then word load
        do_req(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("wst_lat", lat, 2);
        chk("wst_err", {31'd0, er}, 32'd0);
        chk("wst_rdata", rd, 32'd0);
        chk("wst_addr", {20'd0, wr_addr}, 32'd4);
        chk("wst_data", wr_data, 32'hDEADBEEF);
        chk("wst_cnt", wr_cnt, 1);
        do_req(0, 0, 2'b00, 0, 32'h10, 32'h0, lat, rd, er);
        chk("wld_lat", lat, 3);
        chk("wld_data", rd, 32'hDEADBEEF);
        chk("wld_err", {31'd0, er}, 32'd0);

        // byte store RMW from m1
        wc = wr_cnt; rc = rd_cnt;
        do_req(1, 1, 2'b10, 0, 32'h11, 32'h000000AA, lat, rd, er);
        chk("bst_lat", lat, 4);
        chk("bst_err", {31'd0, er}, 32'd0);
        chk("bst_merge", wr_data, 32'hDEADAAEF);
        chk("bst_reads", rc + 1, rd_cnt);
        chk("bst_writes", wc + 1, wr_cnt);

        // lane extraction
        do_req(0, 1, 2'b00, 0, 32'h10, 32'h8001FF7F, lat, rd, er);
        do_req(0, 0, 2'b01, 1, 32'h12, 32'h0, lat, rd, er);
        chk("hld_lat", lat, 3);
        chk("hld_hi_sx", rd, 32'hFFFF8001);
        do_req(1, 0, 2'b10, 1, 32'h10, 32'h0, lat, rd, er);
        chk("bld_b0_sx", rd, 32'h0000007F);
        do_req(0, 0, 2'b10, 0, 32'h11, 32'h0, lat, rd, er);
        chk("bld_b1_zx", rd, 32'h000000FF);
        do_req(0, 0, 2'b10, 1, 32'h13, 32'h0, lat, rd, er);
        chk("bld_b3_sx", rd, 32'hFFFFFF80);
        do_req(0, 0, 2'b01, 0, 32'h10, 32'h0, lat, rd, er);
        chk("hld_lo_zx", rd, 32'h0000FF7F);
        do_req(1, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, lat, rd, er);
        chk("hst_lat", lat, 4);
        chk("hst_merge", wr_data, 32'h1234FF7F);

        // rejected requests never touch memory
        wc = wr_cnt; rc = rd_cnt;
        do_req(0, 0, 2'b00, 0, 32'h13, 32'h0, lat, rd, er);
        chk("err_mis_lat", lat, 1);
        chk("err_mis_err", {31'd0, er}, 32'd1);
        do_req(0, 0, 2'b11, 0, 32'h10, 32'h0, lat, rd, er);
        chk("err_ill_lat", lat, 1);
        chk("err_ill_err", {31'd0, er}, 32'd1);
        do_req(0, 0, 2'b00, 0, 32'h00010000, 32'h0, lat, rd, er);
        chk("err_rng_lat", lat, 1);
        chk("err_rng_err", {31'd0, er}, 32'd1);
        chk("err_rng_rdata", rd, 32'd0);
        do_req(1, 1, 2'b01, 0, 32'h11, 32'h5555, lat, rd, er);
        chk("err_half_err", {31'd0, er}, 32'd1);
        chk("err_no_mem", (wr_cnt - wc) + (rd_cnt - rc), 0);

        // top word of memory
        do_req(1, 1, 2'b00, 0, 32'h3FFC, 32'hCAFEF00D, lat, rd, er);
        chk("top_wst_addr", {20'd0, wr_addr}, 32'hFFF);
        do_req(0, 0, 2'b00, 0, 32'h3FFC, 32'h0, lat, rd, er);
        chk("top_wld", rd, 32'hCAFEF00D);
        chk("top_wld_err", {31'd0, er}, 32'd0);

        // reset while a byte store waits for its read data
        do_req(0, 1, 2'b00, 0, 32'h20, 32'h11223344, lat, rd, er);
        wc = wr_cnt;
        wait_idle();
        m1_we = 1; m1_width = 2'b10; m1_sign = 0; m1_addr = 32'h21; m1_wdata = 32'h55; m1_req = 1;
        @(posedge clk); #1;
        chk("rmw_read_issue", {30'd0, mem_en, mem_we}, 32'd2);
        @(posedge clk); #1;
        chk("rmw_wait_busy", {30'd0, busy, mem_en}, 32'd2);
        reset = 1'b1; #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_mem", {19'd0, mem_en, mem_we, mem_addr}, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_ack", {30'd0, m1_ack, m1_err}, 32'd0);
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_mem8", mem[8], 32'h11223344);
        chk("mid_rst_nowrite", wr_cnt, wc);
        do_req(1, 0, 2'b00, 0, 32'h20, 32'h0, lat, rd, er);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 32'h11223344);

        // simultaneous requests held continuously from reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m0_we = 0; m0_width = 2'b00; m0_sign = 0; m0_addr = 32'h10;
        m1_we = 0; m1_width = 2'b00; m1_sign = 0; m1_addr = 32'h20;
        m0_req = 1; m1_req = 1;
        n = 0; dual = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(posedge clk); #1;
            if (m0_ack && m1_ack) dual++;
            if (m0_ack) begin order[n] = 0; got[n] = m0_rdata; n++; end
            else if (m1_ack) begin order[n] = 1; got[n] = m1_rdata; n++; end
        end
        m0_req = 0; m1_req = 0;
        chk("arb_count", n, 4);
        chk("arb_dual", dual, 0);
        chk("arb_0", order[0], 0);
        chk("arb_1", order[1], 1);
        chk("arb_2", order[2], 0);
        chk("arb_3", order[3], 1);
        chk("arb_d0", got[0], 32'h1234FF7F);
        chk("arb_d1", got[1], 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares one word-wide synchronous data SRAM between two requesters: m0 = CPU MEM stage, m1 = DMA/debug port.
- Sequences word/half/byte loads and stores onto a memory that only supports whole-word reads and writes.
- Half/byte stores use read-modify-write; loads are extracted and sign/zero-extended.
- Sits between the CPU/bridge and the SRAM macro; replaces direct DM access.

Parameters:
- ADDR_W, 12, word-address width; memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mN_req  in  1  request, N=0,1; held with fields stable until mN_ack
- mN_we  in  1  1=store, 0=load
- mN_width  in  2  00 word, 01 half, 10 byte, 11 illegal
- mN_sign  in  1  load sign-extend enable
- mN_addr  in  32  byte address
- mN_wdata  in  32  store data, right-aligned for half/byte
- mN_ack  out  1  one-cycle completion pulse
- mN_err  out  1  valid with mN_ack; 1 = rejected, no memory access
- mN_rdata  out  32  load result, valid with mN_ack
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM whole-word write
- mem_addr  out  ADDR_W  SRAM word index
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with mem_we=0
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all ack/err/rdata 0; mem_en, mem_we, mem_addr, mem_wdata 0; busy 0; FSM IDLE; last_grant=1.
- Reset is asynchronous. Reset mid-operation drops the transaction, gives no ack, and no write completes. mem_* outputs fall to 0 immediately.
- FSM states: IDLE, READ, WAIT_RD, WRITE, RESP.
- IDLE, arbitration:
  - If one req is high, grant it.
  - If both are high, grant the master not equal to last_grant, then update last_grant.
  - Latch we, width, sign, addr, wdata and the grant id.
- IDLE, next state:
  - Error: width=11, or misaligned (word addr[1:0]!=0, half addr[0]!=0), or addr[31:ADDR_W+2]!=0 → RESP with err=1.
  - Word store → WRITE.
  - Load or half/byte store → READ.
- READ: mem_en=1, mem_we=0, mem_addr=addr[ADDR_W+1:2] → WAIT_RD.
- WAIT_RD, load:
  - Extract lane: half uses addr[1] (0 → [15:0], 1 → [31:16]); byte uses addr[1:0] (0..3 → [7:0]..[31:24]).
  - Extend by sign (1 → replicate top bit, 0 → zeros). Register the result → RESP.
- WAIT_RD, half/byte store: merge wdata low bits into the same lane of mem_rdata, keep the other lanes, register merged word → WRITE.
- WRITE: mem_en=1, mem_we=1, mem_addr as above, mem_wdata = wdata (word) or merged word → RESP.
- RESP: granted mN_ack=1 for exactly one cycle with rdata/err. Word-store and error rdata = 0. → IDLE.
- mem_* outputs are 0 in IDLE, WAIT_RD and RESP.
- Latency from req sampled in IDLE to ack: error 1 cycle, word store 2, load 3, half/byte store 4.
- A req still high in the IDLE cycle after its ack is a new request. Requesters must drop req on the edge where they see ack.
- Non-granted mN_ack, mN_err and mN_rdata stay 0.
- No request is accepted while busy. Pending requests wait and are never lost.
- A store completes its WRITE before the other master's READ can issue, so RMW is atomic.

Decomposition:
- Package dm_arbiter_pkg: width codes WORD/HALF/BYTE/ILLEGAL; FSM state encoding; master id constants.
- Sub-module dm_lane (combinational): lane extract + sign/zero extension for loads, and lane merge for stores. Same width and addr[1:0] inputs for both.

Test Plan:
- m0 word store 0x00000010 ← 0xDEADBEEF, then m0 word load 0x10 → mem_we pulse at word index 4; load ack 3 cycles after req with rdata=0xDEADBEEF, err=0.
- Mem[4]=0xDEADBEEF; m1 byte store addr 0x11, wdata 0x000000AA → READ then WRITE mem_wdata=0xDEADAABF... correction: mem_wdata=0xDEADAAEF; ack 4 cycles after req.
- Mem[4]=0x8001FF7F; half load addr 0x12 sign=1 → 0xFFFF8001; byte load addr 0x10 sign=1 → 0x0000007F; byte load addr 0x11 sign=0 → 0x000000FF.
- m0 and m1 both req from reset (last_grant=1) → m0 served first, m1 acked next. Repeated simultaneous reqs alternate m1, m0.
- m0 word load addr 0x13, then width=11, then addr 0x0001_0000 (ADDR_W=12) → each ack after 1 cycle with err=1; mem_en never asserted.
- Assert reset during WAIT_RD of a byte store → no WRITE, no ack, all outputs 0 at once. After release, mem[] is unchanged and the next request is served normally.
